divider: RTL and testbench



---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 21 ++
 rtl/divider.sv | 142 ++++++++++++++
 tb/tb_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings and defaults for the sequential divider and multiplier.
// Optional zero-divisor shortcut in divider: DIV_ZERO_DETECT_EN.
package div_pkg;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of |divisor| from the
// shifted partial remainder, producing the next remainder and quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_sh,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             q_bit
);

    logic w_ge;

    // A non-negative trial always fits in WIDTH bits, so the low bits suffice.
    assign w_ge    = (rem_sh >= {1'b0, dsr});
    assign q_bit   = w_ge;
    assign rem_nxt = w_ge ? (rem_sh[WIDTH-1:0] - dsr) : rem_sh[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN for the one-cycle zero-divisor path.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             op_start,
    input  logic             op_clear,
    output logic             op_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
`ifdef DIV_ZERO_DETECT_EN
    output logic             div_by_zero,
`endif
    output logic [1:0]       state,
    output logic [CNT_W-1:0] count
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_done;
`ifdef DIV_ZERO_DETECT_EN
    logic             r_dbz;
`endif

    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dsr_abs;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_qmag;
    logic             w_qbit;
    logic             w_last;

    assign w_dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dsr_abs = divisor[WIDTH-1] ? -divisor : divisor;
    assign w_qmag    = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_last    = (r_count == CNT_W'(WIDTH - 1));

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_sh (
            {r_rem, r_dvd[WIDTH-1]}
        ),
        .dsr    (r_dsr),
        .rem_nxt(w_rem_nxt),
        .q_bit  (w_qbit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_dsr    <= '0;
            r_quot   <= '0;
            r_remo   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_done   <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            r_dbz    <= 1'b0;
`endif
        end else if (op_clear) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_done  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            r_dbz   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_start) begin
`ifdef DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            r_state <= ST_DONE;
                            r_quot  <= '1;
                            r_remo  <= dividend;
                            r_done  <= 1'b1;
                            r_dbz   <= 1'b1;
                        end else
`endif
                        begin
                            r_dvd    <= w_dvd_abs;
                            r_dsr    <= w_dsr_abs;
                            r_rem    <= '0;
                            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_sign_r <= dividend[WIDTH-1];
                            r_count  <= '0;
                            r_state  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_rem   <= w_rem_nxt;
                    r_dvd   <= w_qmag;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_quot  <= r_sign_q ? -w_qmag : w_qmag;
                        r_remo  <= r_sign_r ? -w_rem_nxt : w_rem_nxt;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign op_done   = r_done;
    assign quotient  = r_quot;
    assign remainder = r_remo;
    assign state     = r_state;
    assign count     = r_count;
`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = r_dbz;
`endif

endmodule

// File: tb/tb_divider.sv
// Randomised self-checking bench for divider against a plain-arithmetic
// model of signed truncating division.
module tb_divider;

    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        op_start;
    logic        op_clear;
    logic        op_done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic [1:0]  state;
    logic [6:0]  count;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_by_zero;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    divider dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .dividend (dividend),
        .divisor  (divisor),
        .op_start (op_start),
        .op_clear (op_clear),
        .op_done  (op_done),
        .quotient (quotient),
        .remainder(remainder),
`ifdef DIV_ZERO_DETECT_EN
        .div_by_zero(div_by_zero),
`endif
        .state    (state),
        .count    (count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q,
                                  output logic [63:0] r);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        if (b == 64'd0) begin
`ifdef DIV_ZERO_DETECT_EN
            q = '1;
`else
            // magnitude is all ones; negating it gives 1
            q = a[63] ? 64'd1 : '1;
`endif
            r = a;
        end else if (a == MIN && b == '1) begin
            q = MIN;
            r = 64'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    function automatic logic [63:0] mag(input logic [63:0] v);
        return v[63] ? -v : v;
    endfunction

    task automatic run(input logic [63:0] a, input logic [63:0] b,
                       input bit hold, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        lat = 0;
        for (int i = 0; i < 200 && !op_done; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                dividend = {$urandom, $urandom};
                divisor  = {$urandom, $urandom};
                if (!hold) op_start = 1'b0;
            end
        end
        chk("done_seen", {63'd0, op_done}, 64'd1);
    endtask

    task automatic clear(input string tag);
        @(negedge clk);
        op_clear = 1'b1;
        op_start = 1'b0;
        @(negedge clk);
        op_clear = 1'b0;
        chk({tag, "_st"}, {62'd0, state}, 64'd0);
        chk({tag, "_dn"}, {63'd0, op_done}, 64'd0);
        chk({tag, "_q"}, quotient, 64'd0);
        chk({tag, "_r"}, remainder, 64'd0);
    endtask

    logic [63:0] da[7];
    logic [63:0] db[7];
    logic [63:0] eq;
    logic [63:0] er;
    logic [63:0] ra;
    logic [63:0] rb;
    int          lat;
    int          elat;

    initial begin
        reset_n  = 1'b0;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_st", {62'd0, state}, 64'd0);
        chk("rst_cnt", {57'd0, count}, 64'd0);
        chk("rst_dn", {63'd0, op_done}, 64'd0);
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", remainder, 64'd0);
        reset_n = 1'b1;

        run(64'd17, 64'd5, 1'b1, lat);
        chk("lat_17_5", lat, 65);
        chk("q_17_5", quotient, 64'd3);
        chk("r_17_5", remainder, 64'd2);
        chk("cnt_done", {57'd0, count}, 64'd64);
        repeat (5) @(negedge clk);
        chk("hold_st", {62'd0, state}, 64'd2);
        chk("hold_q", quotient, 64'd3);
        chk("hold_r", remainder, 64'd2);
        clear("clr1");

        da = '{-64'sd7, 64'd7, MIN, 64'd5, -64'sd5, MIN, -64'sd17};
        db = '{64'd2, -64'sd2, '1, 64'd0, 64'd0, 64'd1, -64'sd5};
        for (int i = 0; i < 7; i++) begin
            model(da[i], db[i], eq, er);
            elat = 65;
`ifdef DIV_ZERO_DETECT_EN
            if (db[i] == 64'd0) elat = 1;
`endif
            run(da[i], db[i], 1'b0, lat);
            chk($sformatf("lat_%0d", i), lat, elat);
            chk($sformatf("q_%0d", i), quotient, eq);
            chk($sformatf("r_%0d", i), remainder, er);
`ifdef DIV_ZERO_DETECT_EN
            chk($sformatf("dbz_%0d", i), {63'd0, div_by_zero},
                {63'd0, db[i] == 64'd0});
`endif
            clear($sformatf("clr_d%0d", i));
        end

        @(negedge clk);
        dividend = 64'h1111_1001_1111_1010;
        divisor  = 64'h1001_0011;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        for (int i = 0; i < 100 && count != 7'd30; i++) @(negedge clk);
        chk("mid_cnt", {57'd0, count}, 64'd30);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        chk("mid_st", {62'd0, state}, 64'd0);
        chk("mid_cnt0", {57'd0, count}, 64'd0);
        chk("mid_dn", {63'd0, op_done}, 64'd0);
        chk("mid_q", quotient, 64'd0);
        run(64'h1111_1001_1111_1010, 64'h1001_0011, 1'b0, lat);
        model(64'h1111_1001_1111_1010, 64'h1001_0011, eq, er);
        chk("mid_rq", quotient, eq);
        chk("mid_rr", remainder, er);
        clear("clr_mid");

        @(negedge clk);
        dividend = 64'd1000;
        divisor  = 64'd3;
        op_start = 1'b1;
        repeat (10) @(negedge clk);
        op_start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_st", {62'd0, state}, 64'd0);
        chk("arst_cnt", {57'd0, count}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ra = 64'($signed(32'($urandom_range(0, 2000000)) - 32'd1000000));
                1: rb = 64'($signed(32'($urandom_range(1, 2000)) - 32'd1000));
                2: rb = rb >> $urandom_range(1, 62);
                default: ;
            endcase
            if (rb == 64'd0) rb = 64'd7;
            model(ra, rb, eq, er);
            run(ra, rb, 1'b0, lat);
            chk("rnd_q", quotient, eq);
            chk("rnd_r", remainder, er);
            chk("rnd_id", quotient * rb + remainder, ra);
            chk("rnd_mag", {63'd0, mag(remainder) < mag(rb)}, 64'd1);
            @(negedge clk);
            op_clear = 1'b1;
            @(negedge clk);
            op_clear = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
